// File: rtl/hash_request_arbiter.sv
// hash_request_arbiter: round-robin sharing of one hash generator among NUM_REQ requesters.
// Define HASH_ARB_TIMEOUT_EN to enable the A_AWAIT watchdog (limit TIMEOUT_CYCLES).

package types_pkg;
   typedef enum logic [1:0] {
      H_GROUND = 2'd0,
      H_INIT   = 2'd1,
      H_READY  = 2'd2,
      H_BUSY   = 2'd3
   } hash_generator_state_t;
endpackage

module hash_request_arbiter
   import types_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_pulse_in,
   output logic [NUM_REQ-1:0]         req_busy_out,
   input  hash_generator_state_t      hash_generator_state,
   output logic                       hash_req_pulse_out,
   input  logic [7:0]                 hash_byte,
   input  logic                       hash_byte_pulse,
   output logic [7:0]                 hash_byte_out,
   output logic [NUM_REQ-1:0]         hash_byte_pulse_out,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx_out,
   output logic [2:0]                 err_out
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("hash_request_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {
      A_IDLE    = 2'd0,
      A_AWAIT   = 2'd1,
      A_DELIVER = 2'd2
   } arb_state_t;

   arb_state_t         arb_state_q, arb_state_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [7:0]         byte_q, byte_d;
   logic               hreq_q, hreq_d;
   logic [NUM_REQ-1:0] bpulse_q, bpulse_d;
   logic [2:0]         err_q, err_d;
   logic [NUM_REQ-1:0] cand;
   logic [IDX_W-1:0]   sel, idx;
   logic               found;
   logic               eligible;

`ifdef HASH_ARB_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
`endif

   assign eligible = (hash_generator_state == H_GROUND) || (hash_generator_state == H_READY);

   // Round-robin search starting just above the last grant.
   always_comb begin
      cand  = pending_q | req_pulse_in;
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((32'(last_grant_q) + k) % NUM_REQ);
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      arb_state_d  = arb_state_q;
      pending_d    = pending_q | req_pulse_in;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      byte_d       = byte_q;
      hreq_d       = 1'b0;
      bpulse_d     = '0;
      err_d        = err_q;
`ifdef HASH_ARB_TIMEOUT_EN
      wd_d         = wd_q;
`endif
      if ((req_pulse_in & pending_q) != '0) err_d[0] = 1'b1;
      if (hash_byte_pulse && (arb_state_q != A_AWAIT)) err_d[1] = 1'b1;

      case (arb_state_q)
         A_IDLE: begin
            if (found && eligible) begin
               grant_d        = sel;
               last_grant_d   = sel;
               pending_d[sel] = 1'b0;
               hreq_d         = 1'b1;
               arb_state_d    = A_AWAIT;
`ifdef HASH_ARB_TIMEOUT_EN
               wd_d           = '0;
`endif
            end
         end
         A_AWAIT: begin
            if (hash_byte_pulse) begin
               byte_d      = hash_byte;
               bpulse_d    = NUM_REQ'(1) << grant_q;
               arb_state_d = A_DELIVER;
            end
`ifdef HASH_ARB_TIMEOUT_EN
            // Delivery wins over a timeout landing in the same cycle.
            else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               err_d[2]    = 1'b1;
               arb_state_d = A_IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
`endif
         end
         A_DELIVER: arb_state_d = A_IDLE;
         default:   arb_state_d = A_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         arb_state_q  <= A_IDLE;
         pending_q    <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         grant_q      <= '0;
         byte_q       <= '0;
         hreq_q       <= 1'b0;
         bpulse_q     <= '0;
         err_q        <= '0;
`ifdef HASH_ARB_TIMEOUT_EN
         wd_q         <= '0;
`endif
      end else begin
         arb_state_q  <= arb_state_d;
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         byte_q       <= byte_d;
         hreq_q       <= hreq_d;
         bpulse_q     <= bpulse_d;
         err_q        <= err_d;
`ifdef HASH_ARB_TIMEOUT_EN
         wd_q         <= wd_d;
`endif
      end
   end

   // Busy is the only combinational output: pending or currently being served.
   always_comb begin
      req_busy_out = pending_q;
      if (arb_state_q != A_IDLE) req_busy_out[grant_q] = 1'b1;
   end

   assign hash_req_pulse_out  = hreq_q;
   assign hash_byte_out       = byte_q;
   assign hash_byte_pulse_out = bpulse_q;
   assign grant_idx_out       = grant_q;
   assign err_out             = err_q;

endmodule

// File: tb/tb_hash_request_arbiter.sv
// Bench for hash_request_arbiter: directed vector table, a watchdog sequence when
// HASH_ARB_TIMEOUT_EN is defined, and randomized traffic against a reference model.

module tb_hash_request_arbiter;
   import types_pkg::*;

   localparam int unsigned N  = 2;
   localparam int unsigned TC = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N-1:0]          req_pulse_in;
   logic [N-1:0]          req_busy_out;
   hash_generator_state_t hash_generator_state;
   logic                  hash_req_pulse_out;
   logic [7:0]            hash_byte;
   logic                  hash_byte_pulse;
   logic [7:0]            hash_byte_out;
   logic [N-1:0]          hash_byte_pulse_out;
   logic [0:0]            grant_idx_out;
   logic [2:0]            err_out;

   int n_checks = 0;
   int n_errors = 0;

   hash_request_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TC)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .req_pulse_in        (req_pulse_in),
      .req_busy_out        (req_busy_out),
      .hash_generator_state(hash_generator_state),
      .hash_req_pulse_out  (hash_req_pulse_out),
      .hash_byte           (hash_byte),
      .hash_byte_pulse     (hash_byte_pulse),
      .hash_byte_out       (hash_byte_out),
      .hash_byte_pulse_out (hash_byte_pulse_out),
      .grant_idx_out       (grant_idx_out),
      .err_out             (err_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                  rst;
      logic [1:0]            req;
      hash_generator_state_t hs;
      logic [7:0]            hb;
      logic                  hp;
      logic                  ex_hreq;
      logic [1:0]            ex_bp;
      logic [7:0]            ex_byte;
      logic                  ex_grant;
      logic [1:0]            ex_busy;
      logic [2:0]            ex_err;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic r, input logic [1:0] rq, input hash_generator_state_t hs,
                      input logic [7:0] hb, input logic hp, input logic eh, input logic [1:0] eb,
                      input logic [7:0] ey, input logic eg, input logic [1:0] eu, input logic [2:0] ee);
      vec_t v;
      v.rst = r; v.req = rq; v.hs = hs; v.hb = hb; v.hp = hp;
      v.ex_hreq = eh; v.ex_bp = eb; v.ex_byte = ey; v.ex_grant = eg; v.ex_busy = eu; v.ex_err = ee;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [N-1:0] rq, input hash_generator_state_t hs,
                        input logic [7:0] hb, input logic hp);
      rst = r; req_pulse_in = rq; hash_generator_state = hs; hash_byte = hb; hash_byte_pulse = hp;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: transaction phases tracked as plain integers.
   bit         m_pend[N];
   int         m_phase;   // 0 idle, 1 waiting for byte, 2 delivering
   int         m_grant, m_last, m_wait;
   logic [7:0] m_byte;
   logic [2:0] m_err;
   logic       m_hreq;
   logic [N-1:0] m_bp;

   task automatic model_step(input logic r, input logic [N-1:0] rq, input hash_generator_state_t hs,
                             input logic [7:0] hb, input logic hp);
      int sel;
      m_hreq = 1'b0;
      m_bp   = '0;
      if (r) begin
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_phase = 0; m_last = N - 1; m_grant = 0; m_byte = 8'h00; m_err = 3'b000; m_wait = 0;
         return;
      end
      for (int i = 0; i < N; i++) if (rq[i] && m_pend[i]) m_err[0] = 1'b1;
      if (hp && m_phase != 1) m_err[1] = 1'b1;
      sel = -1;
      if (m_phase == 0 && (hs == H_GROUND || hs == H_READY))
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (sel < 0 && (m_pend[j] || rq[j])) sel = j;
         end
      for (int i = 0; i < N; i++) if (rq[i]) m_pend[i] = 1'b1;
      case (m_phase)
         0: if (sel >= 0) begin
               m_pend[sel] = 1'b0; m_grant = sel; m_last = sel;
               m_hreq = 1'b1; m_phase = 1; m_wait = 0;
            end
         1: if (hp) begin
               m_byte = hb; m_bp[m_grant] = 1'b1; m_phase = 2;
            end else begin
`ifdef HASH_ARB_TIMEOUT_EN
               m_wait++;
               if (m_wait == TC) begin m_phase = 0; m_err[2] = 1'b1; end
`endif
            end
         default: m_phase = 0;
      endcase
   endtask

   function automatic logic [N-1:0] model_busy();
      logic [N-1:0] b;
      for (int i = 0; i < N; i++) b[i] = m_pend[i] || (m_phase != 0 && m_grant == i);
      return b;
   endfunction

   initial begin
      drive(1'b1, '0, H_READY, 8'h00, 1'b0);

      // rst, req, hs, hb, hp | hreq, bpulse, byte, grant, busy, err
      add(1, 2'b00, H_READY,  8'h00, 0,  0, 2'b00, 8'h00, 0, 2'b00, 3'b000);
      add(0, 2'b01, H_READY,  8'h00, 0,  1, 2'b00, 8'h00, 0, 2'b01, 3'b000);
      add(0, 2'b00, H_READY,  8'hA5, 1,  0, 2'b01, 8'hA5, 0, 2'b01, 3'b000);
      add(0, 2'b00, H_READY,  8'h00, 0,  0, 2'b00, 8'hA5, 0, 2'b00, 3'b000);
      add(1, 2'b00, H_READY,  8'h00, 0,  0, 2'b00, 8'h00, 0, 2'b00, 3'b000);
      add(0, 2'b11, H_READY,  8'h00, 0,  1, 2'b00, 8'h00, 0, 2'b11, 3'b000);
      add(0, 2'b00, H_READY,  8'h11, 1,  0, 2'b01, 8'h11, 0, 2'b11, 3'b000);
      add(0, 2'b00, H_READY,  8'h00, 0,  0, 2'b00, 8'h11, 0, 2'b10, 3'b000);
      add(0, 2'b00, H_READY,  8'h00, 0,  1, 2'b00, 8'h11, 1, 2'b10, 3'b000);
      add(0, 2'b00, H_READY,  8'h22, 1,  0, 2'b10, 8'h22, 1, 2'b10, 3'b000);
      add(0, 2'b00, H_READY,  8'h00, 0,  0, 2'b00, 8'h22, 1, 2'b00, 3'b000);
      add(0, 2'b01, H_BUSY,   8'h00, 0,  0, 2'b00, 8'h22, 1, 2'b01, 3'b000);
      for (int i = 0; i < 9; i++)
         add(0, 2'b00, H_BUSY, 8'h00, 0,  0, 2'b00, 8'h22, 1, 2'b01, 3'b000);
      add(0, 2'b00, H_GROUND, 8'h00, 0,  1, 2'b00, 8'h22, 0, 2'b01, 3'b000);
      add(0, 2'b00, H_GROUND, 8'h33, 1,  0, 2'b01, 8'h33, 0, 2'b01, 3'b000);
      add(0, 2'b00, H_GROUND, 8'h00, 0,  0, 2'b00, 8'h33, 0, 2'b00, 3'b000);
      add(0, 2'b10, H_BUSY,   8'h00, 0,  0, 2'b00, 8'h33, 0, 2'b10, 3'b000);
      add(0, 2'b10, H_BUSY,   8'h00, 0,  0, 2'b00, 8'h33, 0, 2'b10, 3'b001);
      add(0, 2'b00, H_BUSY,   8'h44, 1,  0, 2'b00, 8'h33, 0, 2'b10, 3'b011);
      add(0, 2'b00, H_READY,  8'h00, 0,  1, 2'b00, 8'h33, 1, 2'b10, 3'b011);
      add(0, 2'b10, H_READY,  8'h00, 0,  0, 2'b00, 8'h33, 1, 2'b10, 3'b011);
      add(1, 2'b00, H_READY,  8'h00, 0,  0, 2'b00, 8'h00, 0, 2'b00, 3'b000);
      add(0, 2'b00, H_READY,  8'h55, 1,  0, 2'b00, 8'h00, 0, 2'b00, 3'b010);
      add(0, 2'b11, H_READY,  8'h00, 0,  1, 2'b00, 8'h00, 0, 2'b11, 3'b010);
      add(0, 2'b00, H_READY,  8'h66, 1,  0, 2'b01, 8'h66, 0, 2'b11, 3'b010);
      add(0, 2'b00, H_READY,  8'h00, 0,  0, 2'b00, 8'h66, 0, 2'b10, 3'b010);
      add(0, 2'b00, H_READY,  8'h00, 0,  1, 2'b00, 8'h66, 1, 2'b10, 3'b010);
      add(0, 2'b00, H_READY,  8'h77, 1,  0, 2'b10, 8'h77, 1, 2'b10, 3'b010);
      add(0, 2'b00, H_READY,  8'h00, 0,  0, 2'b00, 8'h77, 1, 2'b00, 3'b010);

      foreach (vt[i]) begin
         drive(vt[i].rst, vt[i].req, vt[i].hs, vt[i].hb, vt[i].hp);
         step();
         chk($sformatf("vec%0d hreq", i),  32'(hash_req_pulse_out),  32'(vt[i].ex_hreq));
         chk($sformatf("vec%0d bpulse", i), 32'(hash_byte_pulse_out), 32'(vt[i].ex_bp));
         chk($sformatf("vec%0d byte", i),  32'(hash_byte_out),       32'(vt[i].ex_byte));
         chk($sformatf("vec%0d grant", i), 32'(grant_idx_out),       32'(vt[i].ex_grant));
         chk($sformatf("vec%0d busy", i),  32'(req_busy_out),        32'(vt[i].ex_busy));
         chk($sformatf("vec%0d err", i),   32'(err_out),             32'(vt[i].ex_err));
      end

`ifdef HASH_ARB_TIMEOUT_EN
      // Watchdog: grant with no hash byte, back to idle after TC await cycles.
      drive(1'b1, 2'b00, H_READY, 8'h00, 1'b0); step();
      drive(1'b0, 2'b01, H_READY, 8'h00, 1'b0); step();
      chk("wd hreq", 32'(hash_req_pulse_out), 32'd1);
      drive(1'b0, 2'b00, H_READY, 8'h00, 1'b0);
      for (int k = 2; k <= int'(TC); k++) begin
         step();
         chk($sformatf("wd await%0d busy", k), 32'(req_busy_out), 32'd1);
      end
      step();
      chk("wd idle busy", 32'(req_busy_out),        32'd0);
      chk("wd err",       32'(err_out),             32'b100);
      chk("wd bpulse",    32'(hash_byte_pulse_out), 32'd0);
`endif

      // Randomized traffic checked cycle by cycle against the model.
      drive(1'b1, '0, H_READY, 8'h00, 1'b0);
      model_step(1'b1, '0, H_READY, 8'h00, 1'b0);
      step();
      for (int c = 0; c < 3000; c++) begin
         logic                  r, hp;
         logic [N-1:0]          rq;
         hash_generator_state_t hs;
         logic [7:0]            hb;
         r  = ($urandom % 250) == 0;
         for (int i = 0; i < N; i++) rq[i] = ($urandom % 6) == 0;
         hs = hash_generator_state_t'($urandom_range(0, 3));
         hb = 8'($urandom);
         hp = ($urandom % 4) == 0;
         drive(r, rq, hs, hb, hp);
         model_step(r, rq, hs, hb, hp);
         step();
         chk("rnd hreq",   32'(hash_req_pulse_out),  32'(m_hreq));
         chk("rnd bpulse", 32'(hash_byte_pulse_out), 32'(m_bp));
         chk("rnd byte",   32'(hash_byte_out),       32'(m_byte));
         chk("rnd grant",  32'(grant_idx_out),       32'(m_grant));
         chk("rnd busy",   32'(req_busy_out),        32'(model_busy()));
         chk("rnd err",    32'(err_out),             32'(m_err));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
